// File: rtl/dmem_dma_engine.sv
// Block COPY/FILL initiator for the 16-bit data memory port; COPY costs 2 cycles/word, FILL 1 cycle/word.
// No backpressure: the memory is assumed to accept every access in the cycle it is driven.
module dmem_dma_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic OP_FILL = 1'b1;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0]  words_done_q, words_done_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    hold_d       = hold_q;
    fill_d       = fill_q;
    words_done_d = words_done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d         = op;
          src_d        = src_addr;
          dst_d        = dst_addr;
          rem_d        = len;
          fill_d       = fill_value;
          words_done_d = '0;
          if (len == '0)
            state_d = S_DONE;
          else if (op == OP_FILL)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        hold_d  = mem_read_data;
        src_d   = src_q + ADDR_W'(1);
        state_d = abort ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // The write in this cycle commits even when aborted, so it is always counted.
        dst_d        = dst_q + ADDR_W'(1);
        words_done_d = words_done_q + LEN_W'(1);
        rem_d        = rem_q - LEN_W'(1);
        if (abort || rem_q == LEN_W'(1))
          state_d = S_DONE;
        else
          state_d = (op_q == OP_FILL) ? S_WRITE : S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-side outputs are precomputed from next state so they leave straight from flops.
  always_comb begin
    rd_d    = (state_d == S_READ);
    we_d    = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == S_READ) begin
      addr_d = src_d;
    end else if (state_d == S_WRITE) begin
      addr_d  = dst_d;
      wdata_d = (op_d == OP_FILL) ? fill_d : hold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      hold_q       <= '0;
      fill_q       <= '0;
      words_done_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      hold_q       <= hold_d;
      fill_q       <= fill_d;
      words_done_q <= words_done_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_access_addr = addr_q;
  assign mem_write_data  = wdata_q;
  assign mem_write_en    = we_q;
  assign mem_read        = rd_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign words_done      = words_done_q;

endmodule

// File: tb/tb_dmem_dma_engine.sv
// Directed bench for dmem_dma_engine with a behavioural 64K x 16 data memory.
module tb_dmem_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic [15:0] fill_value;
  logic        abort;
  logic [15:0] mem_read_data;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic        busy;
  logic        done;
  logic [15:0] words_done;

  dmem_dma_engine #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill_value(fill_value), .abort(abort),
    .mem_read_data(mem_read_data), .mem_access_addr(mem_access_addr),
    .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read(mem_read), .busy(busy), .done(done), .words_done(words_done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic        bd_we;
  logic [15:0] bd_a;
  logic [15:0] bd_d;

  assign mem_read_data = mem_read ? mem[mem_access_addr] : 16'h0000;

  always @(posedge clk) begin
    if (mem_write_en)
      mem[mem_access_addr] <= mem_write_data;
    else if (bd_we)
      mem[bd_a] <= bd_d;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cyc;
  logic [15:0] log_addr [$];
  logic        log_wr   [$];
  int          log_cyc  [$];

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Presents a command for one edge; returns at the negedge of cycle 1.
  task automatic issue(input logic o, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l, input logic [15:0] f);
    start = 1'b1; op = o; src_addr = s; dst_addr = d; len = l; fill_value = f;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Logs each memory access per cycle until done; aborts / restarts at given cycle numbers.
  task automatic run(input int abort_cyc, input int restart_cyc, input int max_cyc);
    log_addr.delete(); log_wr.delete(); log_cyc.delete();
    done_cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      abort = (c == abort_cyc);
      if (c == restart_cyc) begin
        start = 1'b1; op = 1'b0; src_addr = 16'h0100; dst_addr = 16'h0200;
        len = 16'd7; fill_value = 16'hDEAD;
      end else begin
        start = 1'b0;
      end
      if (mem_read) begin
        log_addr.push_back(mem_access_addr); log_wr.push_back(1'b0); log_cyc.push_back(c);
      end
      if (mem_write_en) begin
        log_addr.push_back(mem_access_addr); log_wr.push_back(1'b1); log_cyc.push_back(c);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: done not seen within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
    n_cmp++; if ({mem_read, mem_write_en} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b exp 00", {mem_read, mem_write_en}); end
    n_cmp++; if ({mem_access_addr, mem_write_data} !== 32'h0) begin n_fail++; $display("FAIL rst_addr_data got %h exp 0", {mem_access_addr, mem_write_data}); end
    n_cmp++; if (words_done !== 16'd0) begin n_fail++; $display("FAIL rst_words got %0d exp 0", words_done); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) poke(16'(i), 16'(16'h0C00 + i));
    issue(1'b0, 16'h0000, 16'h0010, 16'd4, 16'h0000);
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_write_en !== 1'b1 || words_done !== 16'd1) begin
      n_fail++; $display("FAIL midrun_state got we=%b words=%0d exp we=1 words=1", mem_write_en, words_done);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || mem_write_en !== 1'b0 || words_done !== 16'd0) begin
      n_fail++; $display("FAIL midrun_reset got busy=%b done=%b we=%b words=%0d exp all 0", busy, done, mem_write_en, words_done);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 16'h0000, 16'h0020, 16'd1, 16'h5A5A);
    run(0, 0, 10);
    n_cmp++; if (done_cyc != 2) begin n_fail++; $display("FAIL post_reset_done got %0d exp 2", done_cyc); end
    n_cmp++; if (mem[16'h0020] !== 16'h5A5A || words_done !== 16'd1) begin
      n_fail++; $display("FAIL post_reset_fill got mem=%h words=%0d exp 5a5a 1", mem[16'h0020], words_done);
    end
    @(negedge clk);
  endtask

  task automatic test_fill();
    poke(16'h0001, 16'h0101);
    poke(16'h0005, 16'h0505);
    for (int i = 2; i <= 4; i++) poke(16'(i), 16'h0000);
    issue(1'b1, 16'h0077, 16'h0002, 16'd3, 16'hA5A5);
    run(0, 0, 20);
    n_cmp++; if (done_cyc != 4) begin n_fail++; $display("FAIL fill_done_cycle got %0d exp 4", done_cyc); end
    n_cmp++; if (log_addr.size() != 3) begin n_fail++; $display("FAIL fill_access_count got %0d exp 3", log_addr.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] !== 16'(2 + i) || log_wr[i] !== 1'b1 || log_cyc[i] != i + 1) begin
        n_fail++; $display("FAIL fill_access%0d got addr=%h wr=%b cyc=%0d exp addr=%h wr=1 cyc=%0d",
                           i, log_addr[i], log_wr[i], log_cyc[i], 16'(2 + i), i + 1);
      end
    end
    n_cmp++; if (words_done !== 16'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL fill_words got %0d busy=%b exp 3 busy=1", words_done, busy); end
    for (int i = 2; i <= 4; i++) begin
      n_cmp++; if (mem[i] !== 16'hA5A5) begin n_fail++; $display("FAIL fill_mem%0d got %h exp a5a5", i, mem[i]); end
    end
    n_cmp++; if (mem[1] !== 16'h0101 || mem[5] !== 16'h0505) begin
      n_fail++; $display("FAIL fill_neighbours got %h %h exp 0101 0505", mem[1], mem[5]);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || words_done !== 16'd3) begin
      n_fail++; $display("FAIL fill_idle got busy=%b done=%b words=%0d exp 0 0 3", busy, done, words_done);
    end
  endtask

  task automatic test_copy();
    logic [15:0] exp_a [6];
    exp_a = '{16'h0000, 16'h0005, 16'h0001, 16'h0006, 16'h0002, 16'h0007};
    poke(16'h0000, 16'h1111);
    poke(16'h0001, 16'h2222);
    poke(16'h0002, 16'h3333);
    issue(1'b0, 16'h0000, 16'h0005, 16'd3, 16'hFFFF);
    run(0, 0, 20);
    n_cmp++; if (done_cyc != 7) begin n_fail++; $display("FAIL copy_done_cycle got %0d exp 7", done_cyc); end
    n_cmp++; if (log_addr.size() != 6) begin n_fail++; $display("FAIL copy_access_count got %0d exp 6", log_addr.size()); end
    for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] !== exp_a[i] || log_wr[i] !== 1'(i % 2) || log_cyc[i] != i + 1) begin
        n_fail++; $display("FAIL copy_access%0d got addr=%h wr=%b cyc=%0d exp addr=%h wr=%0d cyc=%0d",
                           i, log_addr[i], log_wr[i], log_cyc[i], exp_a[i], i % 2, i + 1);
      end
    end
    n_cmp++; if (mem[5] !== 16'h1111 || mem[6] !== 16'h2222 || mem[7] !== 16'h3333) begin
      n_fail++; $display("FAIL copy_mem got %h %h %h exp 1111 2222 3333", mem[5], mem[6], mem[7]);
    end
    @(negedge clk);
  endtask

  task automatic test_len0();
    issue(1'b0, 16'h0000, 16'h0009, 16'd0, 16'h0000);
    run(0, 0, 10);
    n_cmp++; if (done_cyc != 1) begin n_fail++; $display("FAIL len0_done_cycle got %0d exp 1", done_cyc); end
    n_cmp++; if (log_addr.size() != 0 || busy !== 1'b1 || words_done !== 16'd0) begin
      n_fail++; $display("FAIL len0_access got n=%0d busy=%b words=%0d exp 0 1 0", log_addr.size(), busy, words_done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 16'h0000, 16'h0030, 16'd4, 16'hBEEF);
    run(0, 2, 20);
    n_cmp++; if (done_cyc != 5) begin n_fail++; $display("FAIL busy_start_done got %0d exp 5", done_cyc); end
    n_cmp++; if (log_addr.size() != 4 || words_done !== 16'd4) begin
      n_fail++; $display("FAIL busy_start_writes got n=%0d words=%0d exp 4 4", log_addr.size(), words_done);
    end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      n_cmp++; if (log_addr[i] !== 16'(16'h0030 + i) || log_wr[i] !== 1'b1) begin
        n_fail++; $display("FAIL busy_start_access%0d got addr=%h wr=%b exp %h 1", i, log_addr[i], log_wr[i], 16'(16'h0030 + i));
      end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) poke(16'(16'h0040 + i), 16'(i + 1));
    for (int i = 0; i < 5; i++) poke(16'(16'h0050 + i), 16'h0000);
    issue(1'b0, 16'h0040, 16'h0050, 16'd5, 16'h0000);
    run(5, 0, 30);
    n_cmp++; if (done_cyc != 6 || words_done !== 16'd2) begin
      n_fail++; $display("FAIL abort_read got done=%0d words=%0d exp 6 2", done_cyc, words_done);
    end
    n_cmp++; if (mem[16'h0051] !== 16'h0002 || mem[16'h0052] !== 16'h0000) begin
      n_fail++; $display("FAIL abort_read_mem got %h %h exp 0002 0000", mem[16'h0051], mem[16'h0052]);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) poke(16'(16'h0050 + i), 16'h0000);
    issue(1'b0, 16'h0040, 16'h0050, 16'd5, 16'h0000);
    run(6, 0, 30);
    n_cmp++; if (done_cyc != 7 || words_done !== 16'd3) begin
      n_fail++; $display("FAIL abort_write got done=%0d words=%0d exp 7 3", done_cyc, words_done);
    end
    n_cmp++; if (mem[16'h0052] !== 16'h0003 || mem[16'h0053] !== 16'h0000) begin
      n_fail++; $display("FAIL abort_write_mem got %h %h exp 0003 0000", mem[16'h0052], mem[16'h0053]);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_overlap();
    issue(1'b1, 16'h0000, 16'hFFFF, 16'd2, 16'h1234);
    run(0, 0, 10);
    n_cmp++; if (done_cyc != 3 || log_addr.size() != 2) begin
      n_fail++; $display("FAIL wrap_count got done=%0d n=%0d exp 3 2", done_cyc, log_addr.size());
    end else begin
      n_cmp++; if (log_addr[0] !== 16'hFFFF || log_addr[1] !== 16'h0000) begin
        n_fail++; $display("FAIL wrap_addr got %h %h exp ffff 0000", log_addr[0], log_addr[1]);
      end
    end
    n_cmp++; if (mem[16'hFFFF] !== 16'h1234 || mem[0] !== 16'h1234) begin
      n_fail++; $display("FAIL wrap_mem got %h %h exp 1234 1234", mem[16'hFFFF], mem[0]);
    end
    @(negedge clk);
    poke(16'h0000, 16'h00AA);
    for (int i = 1; i <= 3; i++) poke(16'(i), 16'(16'h0F00 + i));
    issue(1'b0, 16'h0000, 16'h0001, 16'd3, 16'h0000);
    run(0, 0, 20);
    n_cmp++; if (done_cyc != 7) begin n_fail++; $display("FAIL overlap_done got %0d exp 7", done_cyc); end
    for (int i = 1; i <= 3; i++) begin
      n_cmp++; if (mem[i] !== 16'h00AA) begin n_fail++; $display("FAIL overlap_mem%0d got %h exp 00aa", i, mem[i]); end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_value = '0; abort = 1'b0; bd_we = 1'b0; bd_a = '0; bd_d = '0;
    test_reset();
    test_fill();
    test_copy();
    test_len0();
    test_back_to_back();
    test_abort();
    test_wrap_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
